// File: rtl/multichannel_wr_arbiter_if.sv
// Request/grant and AXI-write-start bundle between four channel write controllers,
// the arbiter and the AXI write master.
interface multichannel_wr_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int LEN_W  = 8
);
    logic [3:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr [4];
    logic [LEN_W-1:0]  wr_len  [4];
    logic [3:0]        wr_grant;
    logic              wr_done;
    logic              axi_wr_start;
    logic [ADDR_W-1:0] axi_wr_addr;
    logic [LEN_W-1:0]  axi_wr_len;
    logic              arb_busy;

    // Arbiter side
    modport slave (
        input  wr_req, wr_addr, wr_len, wr_done,
        output wr_grant, axi_wr_start, axi_wr_addr, axi_wr_len, arb_busy
    );

    // Requesters plus AXI write master, seen as a single environment
    modport master (
        output wr_req, wr_addr, wr_len, wr_done,
        input  wr_grant, axi_wr_start, axi_wr_addr, axi_wr_len, arb_busy
    );
endinterface

// File: rtl/multichannel_wr_arbiter.sv
// Four-channel write arbiter: round-robin grant, one burst outstanding to the AXI write master.
// Build macro WR_ARB_FIXED_PRIO_EN selects fixed priority (channel 0 highest) instead of round-robin.
module multichannel_wr_arbiter #(
    parameter int ADDR_W = 30,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multichannel_wr_arbiter_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [3:0]        r_grant;
    logic              r_start;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_busy;

    logic [1:0]        w_base;
    logic [3:0]        w_rot;
    logic [1:0]        w_offset;
    logic              w_any;
    logic [1:0]        w_winner;
    logic [3:0]        w_onehot;

`ifdef WR_ARB_FIXED_PRIO_EN
    assign w_base = 2'd0;
`else
    // Channel granted most recently; the scan starts just above it.
    logic [1:0]        r_last;
    assign w_base = r_last + 2'd1;
`endif

    // Rotate the request vector so that slot 0 is the highest-priority channel.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign w_rot[gi] = bus.wr_req[w_base + 2'(gi)];
        end
    endgenerate

    always_comb begin
        w_offset = 2'd0;
        w_any    = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = 2'(k);
                w_any    = 1'b1;
            end
        end
    end

    assign w_winner = w_base + w_offset;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_winner == 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
`ifndef WR_ARB_FIXED_PRIO_EN
            r_last  <= 2'd3;
`endif
        end else begin
            r_grant <= '0;
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // wr_done is meaningless here: no burst is outstanding.
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_start <= 1'b1;
                        r_addr  <= bus.wr_addr[w_winner];
                        r_len   <= bus.wr_len[w_winner];
                        r_busy  <= 1'b1;
                        r_state <= ST_BUSY;
`ifndef WR_ARB_FIXED_PRIO_EN
                        r_last  <= w_winner;
`endif
                    end
                end
                ST_BUSY: begin
                    if (bus.wr_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wr_grant     = r_grant;
    assign bus.axi_wr_start = r_start;
    assign bus.axi_wr_addr  = r_addr;
    assign bus.axi_wr_len   = r_len;
    assign bus.arb_busy     = r_busy;

endmodule
